// File: rtl/stream_mem_writer_if.sv
// Stream-in / memory-write bundle for stream_mem_writer.
// The master modport is the environment side: stream source plus memory.
interface stream_mem_writer_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [WIDTH-1:0]      din;
  logic                  input_valid;
  logic                  input_ready;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  write_en;
  logic [WIDTH-1:0]      write_data;

  modport master (
    output din,
    output input_valid,
    input  input_ready,
    input  write_addr,
    input  write_en,
    input  write_data
  );

  modport slave (
    input  din,
    input  input_valid,
    output input_ready,
    output write_addr,
    output write_en,
    output write_data
  );
endinterface

// File: rtl/stream_mem_writer.sv
// Drains a fixed-length burst from a valid/ready stream and writes it
// to sequential addresses of a single-port memory.
module stream_mem_writer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  stream_mem_writer_if.slave    bus,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_written
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_wen;
  logic [WIDTH-1:0]      r_wdata;

  logic w_ready;
  logic w_hs;
  logic w_accept;
  logic w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_hs     = w_ready && bus.input_valid;
  assign w_last   = (r_cnt + LEN_WIDTH'(1)) == r_len;

  // State register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; abort wins over a same-cycle handshake
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = (length == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort)             w_next = S_IDLE;
        else if (w_hs && w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status and stream-ready outputs decoded from state
  always_comb begin
    w_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_ready = !abort;
        busy    = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Command latch and accepted-word counter
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_base <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_base <= base_addr;
      r_len  <= length;
      r_cnt  <= '0;
    end else if (w_hs) begin
      r_cnt <= r_cnt + LEN_WIDTH'(1);
    end
  end

  // Registered memory write port; address wraps naturally
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_hs;
      if (w_hs) begin
        r_waddr <= r_base + ADDR_WIDTH'(r_cnt);
        r_wdata <= bus.din;
      end
    end
  end

  assign bus.input_ready = w_ready;
  assign bus.write_en    = r_wen;
  assign bus.write_addr  = r_waddr;
  assign bus.write_data  = r_wdata;
  assign words_written   = r_cnt;

endmodule

// File: tb/tb_stream_mem_writer.sv
// Directed bench for stream_mem_writer: cycle model plus
// hand-computed burst expectations.
module tb_stream_mem_writer;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int LW = 9;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b1;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_written;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  stream_mem_writer_if #(.WIDTH(W), .ADDR_WIDTH(AW)) sif ();

  stream_mem_writer #(
    .WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .arst_n_in(arst_n_in),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .abort(abort),
    .bus(sif.slave),
    .busy(busy),
    .done(done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 run, 2 done
  int          m_ph = 0;
  int          m_base = 0;
  int          m_len = 0;
  int          m_n = 0;
  logic        m_we = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;

  always @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      m_ph <= 0; m_base <= 0; m_len <= 0; m_n <= 0;
      m_we <= 1'b0; m_addr <= 0; m_data <= '0;
    end else begin
      m_we <= 1'b0;
      case (m_ph)
        0: if (start) begin
          m_base <= int'(base_addr);
          m_len  <= int'(length);
          m_n    <= 0;
          m_ph   <= (length == 0) ? 2 : 1;
        end
        1: if (abort) m_ph <= 0;
        else if (sif.input_valid) begin
          m_we   <= 1'b1;
          m_addr <= (m_base + m_n) % AMOD;
          m_data <= sif.din;
          m_n    <= m_n + 1;
          if (m_n + 1 == m_len) m_ph <= 2;
        end
        default: m_ph <= 0;
      endcase
    end
  end

  // Write / done log for literal checks
  logic [AW-1:0] qa[$];
  logic [31:0]   qd[$];
  int            qc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("write_en", 32'(sif.write_en), 32'(m_we));
    chk("write_addr", 32'(sif.write_addr), 32'(m_addr));
    chk("write_data", sif.write_data, m_data);
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("done", 32'(done), 32'(m_ph == 2));
    chk("input_ready", 32'(sif.input_ready),
        32'((m_ph == 1) && !abort));
    chk("words_written", 32'(words_written), 32'(m_n));
    if (sif.write_en) begin
      qa.push_back(sif.write_addr);
      qd.push_back(sif.write_data);
      qc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step(logic st, logic [AW-1:0] b, logic [LW-1:0] l,
                      logic ab, logic v, logic [31:0] d);
    start = st; base_addr = b; length = l; abort = ab;
    sif.input_valid = v; sif.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 32'h0);
  endtask

  task automatic clr();
    qa.delete(); qd.delete(); qc.delete();
    done_cnt = 0;
  endtask

  int k;
  int k2;
  logic [6:0] pat;
  int j;

  initial begin
    start = 0; base_addr = '0; length = '0; abort = 0;
    sif.input_valid = 0; sif.din = '0;
    #2 arst_n_in = 1'b0;
    #1;
    chk("rst_write_en", 32'(sif.write_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(sif.input_ready), 32'h0);
    chk("rst_ww", 32'(words_written), 32'h0);
    repeat (2) @(posedge clk);
    #1 arst_n_in = 1'b1;
    idle(2);

    // Unstalled burst of 4 at 0x10
    clr();
    k = cyc;
    step(1, 8'h10, 9'd4, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 0, 1, 32'hA0 + i);
    idle(3);
    chk("b1_nwrites", qa.size(), 4);
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      chk("b1_addr", 32'(qa[i]), 32'h10 + i);
      chk("b1_data", qd[i], 32'hA0 + i);
    end
    if (qc.size() == 4) chk("b1_consec", qc[3] - qc[0], 3);
    chk("b1_done_cnt", done_cnt, 1);
    chk("b1_done_lat", done_cyc - k, 5);
    if (qc.size() == 4) chk("b1_done_w4", done_cyc, qc[3]);
    chk("b1_ww", 32'(words_written), 4);

    // Same burst with valid pattern 1,0,0,1,1,0,1
    clr();
    pat = 7'b1011001;
    j = 0;
    k = cyc;
    step(1, 8'h10, 9'd4, 0, 0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        step(0, '0, '0, 0, 1, 32'hB0 + j);
        j++;
      end else begin
        step(0, '0, '0, 0, 0, 32'hDEADBEEF);
      end
    end
    idle(3);
    chk("b2_nwrites", qa.size(), 4);
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      chk("b2_addr", 32'(qa[i]), 32'h10 + i);
      chk("b2_data", qd[i], 32'hB0 + i);
    end
    if (qc.size() == 4) chk("b2_bubble", qc[1] - qc[0], 3);
    chk("b2_done_lat", done_cyc - k, 8);

    // Wrap at 0xFE; start during RUN ignored; back-to-back len 0
    clr();
    k = cyc;
    step(1, 8'hFE, 9'd3, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 8'h00, 9'd7, 0, 1, 32'hC0 + i);
    step(0, '0, '0, 0, 0, 32'h0);
    chk("b3_nwrites", qa.size(), 3);
    if (qa.size() == 3) begin
      chk("b3_addr0", 32'(qa[0]), 32'hFE);
      chk("b3_addr1", 32'(qa[1]), 32'hFF);
      chk("b3_addr2", 32'(qa[2]), 32'h00);
    end
    chk("b3_done_cnt", done_cnt, 1);
    clr();
    k2 = cyc;
    step(1, 8'h33, 9'd0, 0, 1, 32'h55);
    idle(3);
    chk("b4_nwrites", qa.size(), 0);
    chk("b4_done_cnt", done_cnt, 1);
    chk("b4_done_lat", done_cyc - k2, 1);
    chk("b4_ww", 32'(words_written), 0);

    // Abort on third word
    clr();
    step(1, 8'h40, 9'd5, 0, 0, 32'h0);
    step(0, '0, '0, 0, 1, 32'hD0);
    step(0, '0, '0, 0, 1, 32'hD1);
    step(0, '0, '0, 1, 1, 32'hD2);
    chk("b5_idle_busy", 32'(busy), 0);
    idle(2);
    chk("b5_nwrites", qa.size(), 2);
    if (qa.size() == 2) chk("b5_addr1", 32'(qa[1]), 32'h41);
    chk("b5_done_cnt", done_cnt, 0);
    chk("b5_ww", 32'(words_written), 2);
    clr();
    step(1, 8'h50, 9'd1, 1, 0, 32'h0);
    step(0, '0, '0, 0, 1, 32'h77);
    idle(2);
    chk("b6_nwrites", qa.size(), 1);
    if (qa.size() == 1) begin
      chk("b6_addr", 32'(qa[0]), 32'h50);
      chk("b6_data", qd[0], 32'h77);
    end
    chk("b6_done_cnt", done_cnt, 1);

    // Reset mid-burst after two words
    clr();
    step(1, 8'h20, 9'd6, 0, 0, 32'h0);
    step(0, '0, '0, 0, 1, 32'hE0);
    step(0, '0, '0, 0, 1, 32'hE1);
    start = 0; abort = 0; sif.input_valid = 1; sif.din = 32'hE2;
    #2 arst_n_in = 1'b0;
    #1;
    chk("rr_write_en", 32'(sif.write_en), 0);
    chk("rr_write_addr", 32'(sif.write_addr), 0);
    chk("rr_write_data", sif.write_data, 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_ready", 32'(sif.input_ready), 0);
    chk("rr_ww", 32'(words_written), 0);
    sif.input_valid = 0;
    @(posedge clk);
    #1 arst_n_in = 1'b1;
    idle(1);
    chk("rr_done_cnt", done_cnt, 0);
    clr();
    step(1, 8'h30, 9'd2, 0, 0, 32'h0);
    step(0, '0, '0, 0, 1, 32'hF0);
    step(0, '0, '0, 0, 1, 32'hF1);
    idle(3);
    chk("rr_nwrites", qa.size(), 2);
    if (qa.size() == 2) begin
      chk("rr_addr0", 32'(qa[0]), 32'h30);
      chk("rr_data1", qd[1], 32'hF1);
    end
    chk("rr_done_cnt2", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_mem_writer.md
Name: stream_mem_writer

Overview:
- Consumer-side endpoint for a valid/ready stream, such as a fifo output. It drains a fixed-length burst of words and writes them to sequential addresses of a single-port memory write interface.
- A command (start, base_addr, length) is issued by a controller; the block reports busy, a done pulse and a word count.
- It is the reader counterpart of the fifo. It sits between a fifo and an on-chip memory in the accelerator datapath.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 8, memory address width in bits.
- LEN_WIDTH, 9, burst length counter width in bits; maximum burst is 2**LEN_WIDTH-1 words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- arst_n_in  input  1  asynchronous reset, active low.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first write address; latched on accepted start.
- length  input  LEN_WIDTH  number of words in the burst; latched on accepted start.
- abort  input  1  terminates a running burst without a done pulse.
- din  input  WIDTH  stream data.
- input_valid  input  1  stream data valid.
- input_ready  output  1  block accepts data this cycle.
- write_addr  output  ADDR_WIDTH  memory write address, registered.
- write_en  output  1  memory write enable, registered.
- write_data  output  WIDTH  memory write data, registered.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when a burst has completed.
- words_written  output  LEN_WIDTH  handshakes accepted in the current or last burst.

Behaviour:
- Reset (async, arst_n_in=0):
  - State goes to IDLE.
  - write_en, write_addr, write_data, done, busy, input_ready and words_written are all 0.
  - Latched base address and length are cleared.
  - Reset asserted mid-burst discards the burst; no done pulse is produced.
- State machine, states IDLE, RUN and DONE:
  - IDLE: input_ready=0, busy=0.
    - start=1 with length!=0: latch base_addr and length, clear words_written, go to RUN.
    - start=1 with length==0: latch, clear words_written, go directly to DONE. No memory write occurs.
  - RUN: input_ready = !abort; busy=1. A handshake is input_valid && input_ready.
    - On a handshake in cycle T:
      - The next cycle (T+1) shows write_en=1, write_addr = base + words_written (value at T) modulo 2**ADDR_WIDTH, and write_data = din(T).
      - words_written increments.
    - With no handshake, the next cycle shows write_en=0; write_addr and write_data hold their previous values.
    - When the handshake makes words_written equal the latched length, go to DONE. input_ready is 0 from T+1 onward.
    - abort=1 has priority over any handshake in the same cycle. No handshake, no write, go to IDLE, no done pulse; words_written keeps its value.
  - DONE: lasts exactly one cycle, then returns to IDLE.
    - done=1, busy=1, input_ready=0.
    - The write from the final handshake is on the memory bus in this same cycle. Memory contents are valid from the following cycle.
- Command and abort rules:
  - start is ignored in RUN and DONE.
  - start in the first IDLE cycle after DONE is accepted, giving back-to-back bursts with a one-cycle IDLE gap.
  - abort is ignored outside RUN.
- Throughput and latency:
  - One word per cycle is sustained when input_valid is held high.
  - Handshake-to-write latency is 1 cycle.
  - Stalls (input_valid=0) create write_en=0 bubbles and do not advance the address.
- Address wrap: write_addr wraps from 2**ADDR_WIDTH-1 to 0 with no flag.
- Data stability: din is consumed only on a handshake; data presented while input_ready=0 is never written.

Test Plan:
- Reset, then start with base_addr=0x10 and length=4; stream 0xA0..0xA3 with input_valid held high.
  - Required: write_en high for 4 consecutive cycles at addresses 0x10..0x13 with data 0xA0..0xA3.
  - Required: done pulses in the cycle of the 4th write; words_written=4; busy drops the next cycle.
- Same burst with input_valid toggling 1,0,0,1,1,0,1.
  - Required: exactly 4 writes, at 0x10..0x13 in order, with bubbles where valid was low.
  - Required: done arrives 3 cycles later than in the unstalled case.
- base_addr=0xFE, length=3.
  - Required: writes at 0xFE, 0xFF, 0x00; done pulses once.
- start with length=0.
  - Required: no write_en; input_ready stays 0; done pulses in the cycle after start; words_written=0.
- length=5, assert abort together with input_valid on the 3rd word.
  - Required: only 2 writes occur; no done pulse; returns to IDLE the next cycle; words_written=2.
  - Then a start with length=1 completes normally.
- Drive arst_n_in low mid-burst after 2 words.
  - Required: all outputs go to 0 immediately; no done pulse.
  - Required: a new start after reset writes from the new base_addr.
